// File: rtl/sobel_window_reader_if.sv
// sobel_window_reader_if: pixel stream, line-buffer taps and 3x3 window bundle
interface sobel_window_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COL_W      = 8,
  parameter int ROW_W      = 8
);
  logic                    PixelValid;
  logic [DATA_WIDTH-1:0]   PixelIn;
  logic                    PixelReady;
  logic                    LineEnable;
  logic [DATA_WIDTH-1:0]   LineData;
  logic [DATA_WIDTH-1:0]   Tap1In;
  logic [DATA_WIDTH-1:0]   Tap2In;
  logic [9*DATA_WIDTH-1:0] Window;
  logic                    WindowValid;
  logic [COL_W-1:0]        CenterCol;
  logic [ROW_W-1:0]        CenterRow;
  logic                    FrameDone;
  modport master (
    output PixelValid, PixelIn, Tap1In, Tap2In,
    input  PixelReady, LineEnable, LineData, Window, WindowValid, CenterCol, CenterRow, FrameDone
  );
  modport slave (
    input  PixelValid, PixelIn, Tap1In, Tap2In,
    output PixelReady, LineEnable, LineData, Window, WindowValid, CenterCol, CenterRow, FrameDone
  );
endinterface

// File: rtl/sobel_window_reader.sv
// sobel_window_reader: feeds the line-buffer chain and builds a qualified 3x3 window
module sobel_window_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int COL_W      = 8,
  parameter int ROW_W      = 8
) (
  input logic                  CLK,
  input logic                  Reset,
  sobel_window_reader_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;
  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, cc_q, cc_d;
  logic [ROW_W-1:0]  row_q, row_d, cr_q, cr_d;
  logic [9*DW-1:0]   win_q, win_d;
  logic              wv_q, wv_d;
  logic              accept, last_col, last_row;
  always_comb begin
    accept   = bus.PixelValid && state_q == RUN;
    last_col = col_q == LAST_COL;
    last_row = row_q == LAST_ROW;
    state_d  = (accept && last_col && last_row) ? DONE : RUN;
    col_d    = accept ? (last_col ? '0 : col_q + COL_W'(1)) : col_q;
    row_d    = (accept && last_col) ? (last_row ? '0 : row_q + ROW_W'(1)) : row_q;
    // newest column enters at c=2 of each row; oldest column falls off c=0
    win_d    = accept ? {bus.PixelIn, win_q[9*DW-1:7*DW], bus.Tap1In, win_q[6*DW-1:4*DW],
                         bus.Tap2In, win_q[3*DW-1:DW]} : win_q;
    wv_d     = accept && row_q >= ROW_W'(2) && col_q >= COL_W'(2);
    cc_d     = accept ? col_q - COL_W'(1) : cc_q;
    cr_d     = accept ? row_q - ROW_W'(1) : cr_q;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
      cc_q    <= '0;
      cr_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
      cc_q    <= cc_d;
      cr_q    <= cr_d;
    end
  end
  assign bus.PixelReady  = state_q == RUN;
  assign bus.LineEnable  = accept;
  assign bus.LineData    = bus.PixelIn;
  assign bus.Window      = win_q;
  assign bus.WindowValid = wv_q;
  assign bus.CenterCol   = cc_q;
  assign bus.CenterRow   = cr_q;
  assign bus.FrameDone   = state_q == DONE;
endmodule

// File: tb/tb_sobel_window_reader.sv
// tb_sobel_window_reader: 4x4 frames through behavioural line buffers, scoreboarded windows
module tb_sobel_window_reader;
  localparam int DW = 8, W = 4, H = 4, CW = 2, RW = 2;
  typedef struct packed {
    logic [9*DW-1:0] w;
    logic [CW-1:0]   cc;
    logic [RW-1:0]   cr;
  } exp_t;
  logic CLK = 1'b0, Reset = 1'b1;
  always #5 CLK = ~CLK;
  sobel_window_reader_if #(.DATA_WIDTH(DW), .COL_W(CW), .ROW_W(RW)) bus();
  sobel_window_reader #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW))
    dut (.CLK(CLK), .Reset(Reset), .bus(bus));
  logic [3:0][DW-1:0] lb1 = '0, lb2 = '0;
  always @(posedge CLK) if (bus.LineEnable) begin
    lb1 <= {lb1[2:0], bus.LineData};
    lb2 <= {lb2[2:0], lb1[3]};
  end
  assign bus.Tap1In = lb1[3];
  assign bus.Tap2In = lb2[3];
  int n_assert = 0, n_fail = 0, n_win = 0, n_fd = 0;
  int r = 0, c = 0;
  logic [DW-1:0] img [H][W];
  exp_t q[$];
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [71:0] win_at(input int rr, input int cc);
    logic [71:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = img[rr-2+i][cc-2+j];
    return w;
  endfunction
  task automatic send(input logic [DW-1:0] v);
    bit ok, acc;
    exp_t e;
    acc = 1'b0;
    bus.PixelValid = 1'b1;
    bus.PixelIn = v;
    for (int t = 0; t < 8 && !acc; t++) begin
      ok = bus.PixelReady;
      @(posedge CLK);
      #1;
      acc = ok;
    end
    chk("accept", 72'(acc), 72'(1));
    if (acc) begin
      img[r][c] = v;
      if (r >= 2 && c >= 2) begin
        e.w  = win_at(r, c);
        e.cc = CW'(c - 1);
        e.cr = RW'(r - 1);
        q.push_back(e);
      end
      if (c == W - 1) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end else c++;
    end
  endtask
  task automatic stall(input int n, input string tag);
    bus.PixelValid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
      chk({tag, "_line_en"}, 72'(bus.LineEnable), 72'(0));
      chk({tag, "_wv"}, 72'(bus.WindowValid), 72'(0));
    end
  endtask
  always @(negedge CLK) if (!Reset) begin
    if (bus.FrameDone) n_fd++;
    if (bus.WindowValid) begin
      n_win++;
      chk("wv_expected", 72'(q.size() != 0), 72'(1));
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("window", bus.Window, e.w);
        chk("center_col", 72'(bus.CenterCol), 72'(e.cc));
        chk("center_row", 72'(bus.CenterRow), 72'(e.cr));
      end
    end
  end
  initial begin
    bus.PixelValid = 1'b0;
    bus.PixelIn = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_window", bus.Window, 72'(0));
    chk("rst_wv", 72'(bus.WindowValid), 72'(0));
    chk("rst_fd", 72'(bus.FrameDone), 72'(0));
    chk("rst_cc", 72'(bus.CenterCol), 72'(0));
    chk("rst_cr", 72'(bus.CenterRow), 72'(0));
    chk("rst_ready", 72'(bus.PixelReady), 72'(1));
    Reset = 1'b0;
    for (int i = 1; i <= 16; i++) send(DW'(i));
    chk("f1_fd", 72'(bus.FrameDone), 72'(1));
    chk("f1_ready_low", 72'(bus.PixelReady), 72'(0));
    chk("f1_last_wv", 72'(bus.WindowValid), 72'(1));
    @(posedge CLK);
    #1;
    chk("f1_fd_drop", 72'(bus.FrameDone), 72'(0));
    chk("f1_ready_back", 72'(bus.PixelReady), 72'(1));
    chk("f1_windows", 72'(n_win), 72'(4));
    for (int i = 101; i <= 111; i++) send(DW'(i));
    chk("f2_first_00", 72'(bus.Window[DW-1:0]), 72'(101));
    chk("f2_first_22", 72'(bus.Window[9*DW-1:8*DW]), 72'(111));
    for (int i = 112; i <= 116; i++) send(DW'(i));
    chk("f2_fd", 72'(bus.FrameDone), 72'(1));
    for (int i = 1; i <= 7; i++) send(DW'(i));
    stall(3, "f3_stall");
    for (int i = 8; i <= 10; i++) send(DW'(i));
    chk("f2_windows", 72'(n_win), 72'(8));
    Reset = 1'b1;
    bus.PixelValid = 1'b0;
    #1;
    chk("mid_rst_window", bus.Window, 72'(0));
    chk("mid_rst_cc", 72'(bus.CenterCol), 72'(0));
    chk("mid_rst_cr", 72'(bus.CenterRow), 72'(0));
    chk("mid_rst_wv", 72'(bus.WindowValid), 72'(0));
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    r = 0;
    c = 0;
    for (int i = 201; i <= 207; i++) send(DW'(i));
    stall(3, "f4_stall");
    for (int i = 208; i <= 210; i++) send(DW'(i));
    chk("f4_no_wv_at_10", 72'(bus.WindowValid), 72'(0));
    send(DW'(211));
    chk("f4_wv_at_11", 72'(bus.WindowValid), 72'(1));
    stall(2, "f4_hold");
    chk("f4_hold_window", bus.Window, win_at(2, 2));
    for (int i = 212; i <= 216; i++) send(DW'(i));
    chk("f4_fd", 72'(bus.FrameDone), 72'(1));
    chk("f4_last_wv", 72'(bus.WindowValid), 72'(1));
    bus.PixelValid = 1'b0;
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_wv", 72'(bus.WindowValid), 72'(0));
    chk("async_rst_fd", 72'(bus.FrameDone), 72'(0));
    chk("total_windows", 72'(n_win), 72'(12));
    chk("total_frame_done", 72'(n_fd), 72'(3));
    chk("queue_drained", 72'(q.size()), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
